// File: rtl/pc_unit_ras.sv
// Fetch program counter with run/step/halt control and an optional circular return-address stack.
// Optional feature macro: PC_RAS_EN (defined = RAS present; undefined = RAS outputs tied to zero).
module pc_unit_ras #(
  parameter int               NBITS     = 32,
  parameter int               RAS_DEPTH = 4,
  parameter logic [NBITS-1:0] RESET_PC  = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_run_mode,
  input  logic             i_step,
  input  logic             i_stall,
  input  logic             i_halt,
  input  logic             i_jump,
  input  logic [NBITS-1:0] i_jump_target,
  input  logic             i_branch,
  input  logic [NBITS-1:0] i_branch_target,
  input  logic             i_ras_push,
  input  logic             i_ras_pop,
  input  logic [NBITS-1:0] i_link_addr,
  output logic [NBITS-1:0] o_pc,
  output logic [NBITS-1:0] o_pc_4,
  output logic [NBITS-1:0] o_pc_8,
  output logic             o_halted,
  output logic [NBITS-1:0] o_ras_target,
  output logic             o_ras_valid,
  output logic             o_ras_overflow
);

  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [NBITS-1:0] r_pc;
  logic [NBITS-1:0] w_pc_next;
  logic             w_adv;
  logic             w_commit;

  assign w_adv    = (r_state == ST_RUN) & (i_run_mode | i_step);
  // The ID instruction retires only when it is neither stalled nor flushed by an EX redirect.
  assign w_commit = w_adv & ~i_stall & ~i_branch;

  assign o_pc     = r_pc;
  assign o_pc_4   = r_pc + NBITS'(4);
  assign o_pc_8   = r_pc + NBITS'(8);
  assign o_halted = (r_state == ST_HALTED);

  always_comb begin
    w_pc_next    = r_pc;
    w_state_next = r_state;
    if (w_adv) begin
      if (i_branch)
        w_pc_next = i_branch_target;
      else if (i_stall)
        w_pc_next = r_pc;
      else if (i_jump)
        w_pc_next = i_jump_target;
      else
        w_pc_next = r_pc + NBITS'(4);
      if (w_commit & i_halt)
        w_state_next = ST_HALTED;
    end
  end

  always_ff @(negedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc    <= RESET_PC;
      r_state <= ST_RUN;
    end else begin
      r_pc    <= w_pc_next;
      r_state <= w_state_next;
    end
  end

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [NBITS-1:0] r_ras_mem [RAS_DEPTH];
  logic [PW-1:0]    r_ras_ptr;
  logic [CW-1:0]    r_ras_count;
  logic             r_ras_overflow;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_ras_full;
  logic [PW-1:0]    w_ras_waddr;

  assign w_do_push   = w_commit & i_ras_push;
  assign w_do_pop    = w_commit & i_ras_pop;
  assign w_ras_full  = (r_ras_count == CW'(RAS_DEPTH));
  // Push+pop replaces the current top in place; a plain push writes the slot above it.
  assign w_ras_waddr = w_do_pop ? r_ras_ptr : r_ras_ptr + PW'(1);

  always_ff @(negedge i_clk) begin
    if (w_do_push)
      r_ras_mem[w_ras_waddr] <= i_link_addr;
  end

  always_ff @(negedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ras_ptr      <= '0;
      r_ras_count    <= '0;
      r_ras_overflow <= 1'b0;
    end else if (w_do_push && !w_do_pop) begin
      r_ras_ptr <= r_ras_ptr + PW'(1);
      if (w_ras_full)
        r_ras_overflow <= 1'b1;
      else
        r_ras_count <= r_ras_count + CW'(1);
    end else if (w_do_pop && !w_do_push) begin
      if (r_ras_count != '0) begin
        r_ras_ptr   <= r_ras_ptr - PW'(1);
        r_ras_count <= r_ras_count - CW'(1);
      end
    end else if (w_do_push && w_do_pop) begin
      if (r_ras_count == '0)
        r_ras_count <= CW'(1);
    end
  end

  assign o_ras_valid    = (r_ras_count != '0);
  assign o_ras_target   = o_ras_valid ? r_ras_mem[r_ras_ptr] : '0;
  assign o_ras_overflow = r_ras_overflow;
`else
  logic w_unused_ras;
  assign w_unused_ras   = ^{i_ras_push, i_ras_pop, i_link_addr};
  assign o_ras_target   = '0;
  assign o_ras_valid    = 1'b0;
  assign o_ras_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit_ras.sv
// Scoreboard bench for pc_unit_ras: a behavioural model queues expectations, compared after each falling edge.
module tb_pc_unit_ras;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_mode, step, stall, halt, jump, branch, ras_push, ras_pop;
  logic [31:0] jump_target, branch_target, link_addr;
  logic [31:0] pc, pc_4, pc_8, ras_target;
  logic        halted, ras_valid, ras_overflow;

  pc_unit_ras #(.NBITS(32), .RAS_DEPTH(4), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_reset(rst), .i_run_mode(run_mode), .i_step(step), .i_stall(stall),
    .i_halt(halt), .i_jump(jump), .i_jump_target(jump_target), .i_branch(branch),
    .i_branch_target(branch_target), .i_ras_push(ras_push), .i_ras_pop(ras_pop),
    .i_link_addr(link_addr), .o_pc(pc), .o_pc_4(pc_4), .o_pc_8(pc_8), .o_halted(halted),
    .o_ras_target(ras_target), .o_ras_valid(ras_valid), .o_ras_overflow(ras_overflow)
  );

  always #5 clk = ~clk;

`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic        halted;
    logic [31:0] tgt;
    logic        vld;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [31:0] m_pc;
  bit          m_halted;
  bit          m_ovf;
  logic [31:0] m_stack[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.pc     = m_pc;
    e.halted = m_halted;
    e.vld    = (m_stack.size() > 0);
    e.tgt    = e.vld ? m_stack[m_stack.size()-1] : 32'h0;
    e.ovf    = m_ovf;
    return e;
  endfunction

  task automatic compare_outputs(input string tag);
    exp_t e;
    check_val({tag, ".sb"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val({tag, ".pc"},  pc,   e.pc);
      check_val({tag, ".pc4"}, pc_4, e.pc + 32'd4);
      check_val({tag, ".pc8"}, pc_8, e.pc + 32'd8);
      check_val({tag, ".halted"}, {31'b0, halted}, {31'b0, e.halted});
      check_val({tag, ".ras_tgt"}, ras_target, e.tgt);
      check_val({tag, ".ras_vld"}, {31'b0, ras_valid}, {31'b0, e.vld});
      check_val({tag, ".ras_ovf"}, {31'b0, ras_overflow}, {31'b0, e.ovf});
    end
    $display("[%0t] %s pc=%h halted=%0b ras=%h/%0b ovf=%0b", $time, tag, pc, halted,
             ras_target, ras_valid, ras_overflow);
  endtask

  task automatic set_idle();
    run_mode = 0; step = 0; stall = 0; halt = 0; jump = 0; branch = 0;
    ras_push = 0; ras_pop = 0; jump_target = '0; branch_target = '0; link_addr = '0;
  endtask

  // Reset asserted between edges and checked before any falling edge occurs.
  task automatic apply_reset(input string tag);
    @(posedge clk); #2;
    set_idle();
    rst = 1'b1;
    m_pc = 32'h0; m_halted = 0; m_ovf = 0; m_stack.delete();
    exp_q.push_back(model_snapshot());
    #1 compare_outputs(tag);
    #1 rst = 1'b0;
  endtask

  task automatic cycle(input bit rm, input bit st, input bit stl, input bit hlt,
                       input bit jmp, input logic [31:0] jt, input bit br, input logic [31:0] bt,
                       input bit psh, input bit pp, input logic [31:0] lk, input string tag);
    bit adv, commit;
    @(posedge clk); #1;
    run_mode = rm; step = st; stall = stl; halt = hlt; jump = jmp; jump_target = jt;
    branch = br; branch_target = bt; ras_push = psh; ras_pop = pp; link_addr = lk;
    adv    = !m_halted && (rm || st);
    commit = adv && !stl && !br;
    if (adv) begin
      if (commit && RAS_EN) begin
        if (psh && !pp) begin
          m_stack.push_back(lk);
          if (m_stack.size() > DEPTH) begin
            m_stack.delete(0);
            m_ovf = 1;
          end
        end else if (pp && !psh) begin
          if (m_stack.size() > 0) void'(m_stack.pop_back());
        end else if (pp && psh) begin
          if (m_stack.size() > 0) m_stack[m_stack.size()-1] = lk;
          else m_stack.push_back(lk);
        end
      end
      if (br)        m_pc = bt;
      else if (stl)  m_pc = m_pc;
      else if (jmp)  m_pc = jt;
      else           m_pc = m_pc + 32'd4;
      if (commit && hlt) m_halted = 1;
    end
    exp_q.push_back(model_snapshot());
    @(negedge clk); #1;
    compare_outputs(tag);
  endtask

  task automatic run_seq(input string tag);
    cycle(1, 0, 0, 0, 0, '0, 0, '0, 0, 0, '0, tag);
  endtask

  task automatic ras_op(input bit psh, input bit pp, input logic [31:0] lk, input string tag);
    cycle(1, 0, 0, 0, 0, '0, 0, '0, psh, pp, lk, tag);
  endtask

  initial begin
    set_idle();
    apply_reset("reset");

    // Sequential run, then asynchronous reset in the middle of running.
    for (int i = 0; i < 4; i++) run_seq("run");
    apply_reset("reset_mid");

    // Step mode: two pulses across six cycles, then stall holds a stepped PC.
    for (int i = 0; i < 6; i++)
      cycle(0, (i == 0 || i == 3), 0, 0, 0, '0, 0, '0, 0, 0, '0, "step");
    cycle(0, 1, 1, 0, 0, '0, 0, '0, 0, 0, '0, "step_stall");
    cycle(0, 1, 0, 0, 0, '0, 0, '0, 0, 0, '0, "step_held1");
    cycle(0, 1, 0, 0, 0, '0, 0, '0, 0, 0, '0, "step_held2");

    // Redirect priority.
    cycle(1, 0, 0, 0, 1, 32'h20, 0, '0, 0, 0, '0, "jump");
    cycle(1, 0, 0, 0, 1, 32'h100, 1, 32'h40, 0, 0, '0, "br_over_jump");
    cycle(1, 0, 1, 0, 0, '0, 1, 32'h60, 0, 0, '0, "br_over_stall");
    cycle(1, 0, 1, 0, 1, 32'h200, 0, '0, 0, 0, '0, "stall_over_jump");

    // PC wrap.
    cycle(1, 0, 0, 0, 1, 32'hFFFF_FFF8, 0, '0, 0, 0, '0, "to_top");
    run_seq("wrap1");
    run_seq("wrap2");

    // RAS basic push/pop and empty handling; stalled or flushed ops must not commit.
    ras_op(1, 0, 32'h10, "push");
    ras_op(1, 0, 32'h20, "push");
    ras_op(1, 0, 32'h30, "push");
    cycle(1, 0, 1, 0, 0, '0, 0, '0, 1, 0, 32'h99, "push_stalled");
    cycle(1, 0, 0, 0, 0, '0, 1, 32'h80, 0, 1, '0, "pop_flushed");
    ras_op(0, 1, '0, "pop");
    ras_op(0, 1, '0, "pop");
    ras_op(0, 1, '0, "pop");
    ras_op(0, 1, '0, "pop_empty");
    ras_op(1, 0, 32'h44, "push_after_empty");
    ras_op(0, 1, '0, "pop");

    // Overflow: five pushes into four entries, then drain.
    for (int i = 1; i <= 5; i++) ras_op(1, 0, 32'h100 * i, "push_ovf");
    for (int i = 0; i < 4; i++) ras_op(0, 1, '0, "pop_ovf");
    ras_op(0, 1, '0, "pop_empty2");
    ras_op(1, 1, 32'hAB0, "pushpop_empty");
    ras_op(1, 0, 32'hAC0, "push");
    ras_op(1, 1, 32'hAD0, "pushpop_top");
    ras_op(0, 1, '0, "pop");

    // Mixed random traffic with halt kept low.
    for (int i = 0; i < 60; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 4) == 0, 0,
            $urandom_range(0, 3) == 0, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 5) == 0, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom, "rand");

    // Halt at pc=0x8: PC takes 0xC then freezes regardless of step/run/redirects.
    apply_reset("reset_halt");
    run_seq("run");
    run_seq("run");
    cycle(1, 0, 0, 1, 0, '0, 0, '0, 1, 0, 32'h77, "halt");
    for (int i = 0; i < 10; i++)
      cycle(i[0], 1, 0, 0, 1, 32'h500, i[1], 32'h600, 1, 0, 32'h88, "halted_hold");
    apply_reset("reset_after_halt");
    run_seq("run_after_halt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
